// File: rtl/ex_muldiv_unit_if.sv
// Request/response bundle between execute and the M-extension multiply/divide unit.
// Latency: none, wires only.
// Backpressure: valid/ready on both the request and the response channel.
interface ex_muldiv_unit_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_funct3;
    logic [XLEN-1:0]   req_rs1;
    logic [XLEN-1:0]   req_rs2;
    logic [4:0]        req_rd;
    logic [TAG_W-1:0]  req_tag;
    logic              resp_valid;
    logic              resp_ready;
    logic [XLEN-1:0]   resp_data;
    logic [4:0]        resp_rd;
    logic [TAG_W-1:0]  resp_tag;

    modport master (
        output req_valid, req_funct3, req_rs1, req_rs2, req_rd, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_rd, resp_tag
    );

    modport slave (
        input  req_valid, req_funct3, req_rs1, req_rs2, req_rd, req_tag, resp_ready,
        output req_ready, resp_valid, resp_data, resp_rd, resp_tag
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide; MULDIV_EARLY_OUT_EN adds zero-operand / small-dividend early outs.
// Latency: XLEN+1 cycles from accept to resp_valid, 1 cycle on the fast paths.
// Backpressure: result held in DONE until resp_ready; req_ready only in IDLE without flush.
module ex_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    ex_muldiv_unit_if.slave     io,
    output logic                busy
);
    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    typedef struct packed {
        logic [2:0]       funct3;
        logic             neg;
        logic [4:0]       rd;
        logic [TAG_W-1:0] tag;
    } meta_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*XLEN-1:0]  acc_q, acc_d;
    logic [XLEN-1:0]    opb_q, opb_d;
    meta_t              meta_q, meta_d;
    logic               resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]    resp_data_q, resp_data_d;
    logic [4:0]         resp_rd_q, resp_rd_d;
    logic [TAG_W-1:0]   resp_tag_q, resp_tag_d;

    logic               accept, signed_a, signed_b, a_neg, b_neg, res_neg;
    logic [XLEN-1:0]    mag_a, mag_b;
    logic               div_zero, div_ovf, fast;
    logic [XLEN-1:0]    fast_data;

    logic [XLEN:0]      mul_sum;
    logic [2*XLEN-1:0]  mul_next, prod;
    logic [XLEN-1:0]    mul_res;
    logic [XLEN:0]      div_sh, div_diff;
    logic [2*XLEN-1:0]  div_next;
    logic [XLEN-1:0]    div_raw, div_res;

    assign accept   = io.req_valid && io.req_ready;
    assign signed_a = (io.req_funct3 == 3'd1) || (io.req_funct3 == 3'd2) ||
                      (io.req_funct3 == 3'd4) || (io.req_funct3 == 3'd6);
    assign signed_b = (io.req_funct3 == 3'd1) || (io.req_funct3 == 3'd4) ||
                      (io.req_funct3 == 3'd6);
    assign a_neg    = signed_a && io.req_rs1[XLEN-1];
    assign b_neg    = signed_b && io.req_rs2[XLEN-1];
    assign mag_a    = a_neg ? -io.req_rs1 : io.req_rs1;
    assign mag_b    = b_neg ? -io.req_rs2 : io.req_rs2;
    // Remainder follows the dividend's sign; everything else follows a^b.
    assign res_neg  = (io.req_funct3[2] && io.req_funct3[1]) ? a_neg : (a_neg ^ b_neg);
    assign div_zero = io.req_funct3[2] && (io.req_rs2 == '0);
    assign div_ovf  = io.req_funct3[2] && !io.req_funct3[0] &&
                      (io.req_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (io.req_rs2 == '1);

    always_comb begin
        fast      = 1'b0;
        fast_data = '0;
        if (div_zero) begin
            fast      = 1'b1;
            fast_data = io.req_funct3[1] ? io.req_rs1 : '1;
        end else if (div_ovf) begin
            fast      = 1'b1;
            fast_data = io.req_funct3[1] ? '0 : io.req_rs1;
        end
`ifdef MULDIV_EARLY_OUT_EN
        else if (!io.req_funct3[2] && ((io.req_rs1 == '0) || (io.req_rs2 == '0))) begin
            fast      = 1'b1;
            fast_data = '0;
        end else if (io.req_funct3[2] && (mag_a < mag_b)) begin
            fast      = 1'b1;
            fast_data = io.req_funct3[1] ? io.req_rs1 : '0;
        end
`endif
    end

    // acc holds {partial high, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
    assign prod     = meta_q.neg ? -mul_next : mul_next;
    assign mul_res  = (meta_q.funct3 == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    assign div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_diff = div_sh - {1'b0, opb_q};
    assign div_next = div_diff[XLEN] ? {div_sh[XLEN-1:0],   acc_q[XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    assign div_raw  = meta_q.funct3[1] ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
    assign div_res  = meta_q.neg ? -div_raw : div_raw;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        opb_d        = opb_q;
        meta_d       = meta_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_rd_d    = resp_rd_q;
        resp_tag_d   = resp_tag_q;
        unique case (state_q)
            IDLE: if (accept) begin
                meta_d.funct3 = io.req_funct3;
                meta_d.neg    = res_neg;
                meta_d.rd     = io.req_rd;
                meta_d.tag    = io.req_tag;
                acc_d         = {{XLEN{1'b0}}, mag_a};
                opb_d         = mag_b;
                cnt_d         = '0;
                if (fast) begin
                    state_d      = DONE;
                    resp_valid_d = 1'b1;
                    resp_data_d  = fast_data;
                    resp_rd_d    = io.req_rd;
                    resp_tag_d   = io.req_tag;
                end else begin
                    state_d = io.req_funct3[2] ? DIV : MUL;
                end
            end
            MUL, DIV: begin
                acc_d = (state_q == MUL) ? mul_next : div_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d      = DONE;
                    resp_valid_d = 1'b1;
                    resp_data_d  = (state_q == MUL) ? mul_res : div_res;
                    resp_rd_d    = meta_q.rd;
                    resp_tag_d   = meta_q.tag;
                end
            end
            DONE: if (io.resp_ready) begin
                state_d      = IDLE;
                resp_valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        // Flush overrides completion and handshake; the visible result fields keep their old value.
        if (flush && (state_q != IDLE)) begin
            state_d      = IDLE;
            resp_valid_d = 1'b0;
            resp_data_d  = resp_data_q;
            resp_rd_d    = resp_rd_q;
            resp_tag_d   = resp_tag_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            opb_q        <= '0;
            meta_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_rd_q    <= '0;
            resp_tag_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            opb_q        <= opb_d;
            meta_q       <= meta_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_rd_q    <= resp_rd_d;
            resp_tag_q   <= resp_tag_d;
        end
    end

    assign io.req_ready  = (state_q == IDLE) && !flush;
    assign io.resp_valid = resp_valid_q;
    assign io.resp_data  = resp_data_q;
    assign io.resp_rd    = resp_rd_q;
    assign io.resp_tag   = resp_tag_q;
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit at XLEN=32: results, latency, hold, flush and reset.
// Inputs change #1 after a rising edge; outputs are sampled at that same point.
module tb_ex_muldiv_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    logic busy;
    int   errors = 0;
    int   checks = 0;
    int   lat;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int EO_LAT = 1;
`else
    localparam int EO_LAT = 33;
`endif

    ex_muldiv_unit_if #(.XLEN(32), .TAG_W(64)) bus ();

    ex_muldiv_unit #(.XLEN(32), .TAG_W(64)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .io    (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, input logic [63:0] tag);
        bus.req_valid  = 1'b1;
        bus.req_funct3 = f3;
        bus.req_rs1    = a;
        bus.req_rs2    = b;
        bus.req_rd     = rd;
        bus.req_tag    = tag;
        step();
        bus.req_valid  = 1'b0;
    endtask

    // Counts cycles from the accept cycle to the first cycle with resp_valid high.
    task automatic wait_resp(output int l);
        l = 1;
        while (!bus.resp_valid && l < 100) begin
            step();
            l++;
        end
        if (!bus.resp_valid) l = -1;
    endtask

    task automatic take_resp();
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
    endtask

    task automatic run_check(input string name, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] rd, input logic [63:0] tag,
                             input logic [31:0] exp_data, input int exp_lat);
        int l;
        start_op(f3, a, b, rd, tag);
        wait_resp(l);
        check({name, " latency"}, l, exp_lat);
        check({name, " data"}, bus.resp_data, exp_data);
        check({name, " rd"}, bus.resp_rd, rd);
        check({name, " tag"}, bus.resp_tag, tag);
        take_resp();
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_funct3 = '0;
        bus.req_rs1    = '0;
        bus.req_rs2    = '0;
        bus.req_rd     = '0;
        bus.req_tag    = '0;
        bus.resp_ready = 1'b0;

        repeat (3) step();
        check("reset resp_valid", bus.resp_valid, 0);
        check("reset busy", busy, 0);
        check("reset resp_data", bus.resp_data, 0);
        check("reset resp_rd", bus.resp_rd, 0);
        check("reset resp_tag", bus.resp_tag, 0);
        rst = 1'b1;
        step();
        check("idle req_ready", bus.req_ready, 1);

        run_check("mul 7*-3",      3'd0, 32'd7,        32'hFFFFFFFD, 5'd5,  64'h1234,        32'hFFFFFFEB, 33);
        run_check("mulhu -1*-1",   3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  64'hDEAD_0000_0001, 32'hFFFFFFFE, 33);
        run_check("mulh -1*-1",    3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  64'h2,           32'h00000000, 33);
        run_check("mulhsu -1*2",   3'd2, 32'hFFFFFFFF, 32'd2,        5'd8,  64'h3,           32'hFFFFFFFF, 33);
        run_check("div -7/2",      3'd4, 32'hFFFFFFF9, 32'd2,        5'd9,  64'h4,           32'hFFFFFFFD, 33);
        run_check("rem -7/2",      3'd6, 32'hFFFFFFF9, 32'd2,        5'd10, 64'h5,           32'hFFFFFFFF, 33);
        run_check("remu 100/7",    3'd7, 32'd100,      32'd7,        5'd11, 64'h6,           32'd2,        33);
        run_check("divu 100/0",    3'd5, 32'd100,      32'd0,        5'd12, 64'h7,           32'hFFFFFFFF, 1);
        run_check("remu x/0",      3'd7, 32'h1234,     32'd0,        5'd13, 64'h8,           32'h1234,     1);
        run_check("div ovf",       3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd14, 64'h9,           32'h80000000, 1);
        run_check("rem ovf",       3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd15, 64'hA,           32'h00000000, 1);
        run_check("mul 0*5",       3'd0, 32'd0,        32'd5,        5'd16, 64'hB,           32'h00000000, EO_LAT);

        // Result must hold while the consumer stalls.
        start_op(3'd5, 32'd9, 32'd3, 5'd7, 64'h77);
        wait_resp(lat);
        check("hold latency", lat, 33);
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold resp_valid", bus.resp_valid, 1);
            check("hold resp_data", bus.resp_data, 32'd3);
            check("hold req_ready", bus.req_ready, 0);
        end
        take_resp();
        check("release resp_valid", bus.resp_valid, 0);
        check("release req_ready", bus.req_ready, 1);
        check("release busy", busy, 0);

        // Flush during multiply cycle 10, then a divide accepted the next cycle.
        start_op(3'd0, 32'd123, 32'd456, 5'd3, 64'h99);
        repeat (9) step();
        check("busy mid mul", busy, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush resp_valid", bus.resp_valid, 0);
        check("flush busy", busy, 0);
        run_check("divu 9/3 after flush", 3'd5, 32'd9, 32'd3, 5'd2, 64'h100, 32'd3, 33);

        // Flush while idle blocks acceptance.
        bus.req_valid  = 1'b1;
        bus.req_funct3 = 3'd0;
        bus.req_rs1    = 32'd3;
        bus.req_rs2    = 32'd4;
        flush = 1'b1;
        #1;
        check("idle flush req_ready", bus.req_ready, 0);
        step();
        bus.req_valid = 1'b0;
        flush = 1'b0;
        check("idle flush busy", busy, 0);
        check("idle flush resp_valid", bus.resp_valid, 0);

        // Flush together with resp_ready in DONE.
        start_op(3'd5, 32'd100, 32'd0, 5'd4, 64'h55);
        check("fast done valid", bus.resp_valid, 1);
        flush = 1'b1;
        bus.resp_ready = 1'b1;
        step();
        flush = 1'b0;
        bus.resp_ready = 1'b0;
        check("flush+ready resp_valid", bus.resp_valid, 0);
        check("flush+ready busy", busy, 0);
        check("flush keeps resp_tag", bus.resp_tag, 64'h55);

        // Reset in the middle of a multiply clears everything.
        start_op(3'd0, 32'd5, 32'd6, 5'd9, 64'hABC);
        repeat (4) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("midrst resp_valid", bus.resp_valid, 0);
        check("midrst busy", busy, 0);
        check("midrst resp_data", bus.resp_data, 0);
        check("midrst resp_rd", bus.resp_rd, 0);
        check("midrst resp_tag", bus.resp_tag, 0);
        check("midrst req_ready", bus.req_ready, 1);

        run_check("divu 3/9", 3'd5, 32'd3, 32'd9, 5'd20, 64'hC, 32'd0, EO_LAT);
        run_check("remu 3/9", 3'd7, 32'd3, 32'd9, 5'd21, 64'hD, 32'd3, EO_LAT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M/RV64M multiply/divide unit that sits beside the single-cycle execute ALU in the pipeline.
- Execute dispatches M-extension ops (funct7 = 7'b0000001, op_b_reg) here over a valid/ready handshake. Execute stalls until the result returns.
- Carries the rd address and instruction order tag so the result can be written into the ex_mm register and forwarded.
- Generalises execute arithmetic to parametric XLEN and adds multi-cycle, flushable operation.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.
- TAG_W, 64, width of the order tag carried with each op.
- CNT_W, $clog2(XLEN)+1, iteration counter width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-low.
- flush  in  1  kill in-flight op (branch/jump redirect); no response is produced.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_funct3  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- req_rs1  in  XLEN  operand a (already forwarded by execute).
- req_rs2  in  XLEN  operand b.
- req_rd  in  5  destination register.
- req_tag  in  TAG_W  rvfi order of the instruction.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes result.
- resp_data  out  XLEN  result.
- resp_rd  out  5  captured req_rd.
- resp_tag  out  TAG_W  captured req_tag.
- busy  out  1  state != IDLE; execute uses it as a stall source.

Behaviour:
- Reset (rst == 0 at a rising edge): state = IDLE, counter 0, resp_valid 0, resp_data 0, resp_rd 0, resp_tag 0, busy 0. Reset wins over every other input, including mid-operation.
- States: IDLE, MUL, DIV, DONE.
- req_ready = (state == IDLE) && !flush. A request is accepted on an edge where req_valid && req_ready.
- On accept, capture funct3/rd/tag and compute operand magnitudes and result sign:
  - MULH/DIV/REM treat both operands as signed.
  - MULHSU treats only rs1 as signed.
  - Other ops treat both as unsigned.
- Multiply path (funct3 0–3): shift-add, one partial product per cycle, 2*XLEN-bit accumulator. State MUL lasts exactly XLEN cycles, then DONE.
  - MUL returns low XLEN bits of the product; MULH/MULHSU/MULHU return high XLEN bits.
  - Negation of the 2*XLEN product is applied when the result sign is negative.
- Divide path (funct3 4–7): restoring division, one quotient bit per cycle. State DIV lasts exactly XLEN cycles, then DONE.
  - Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
- Fast path: skip MUL/DIV and go straight from IDLE to DONE on the accept edge when either holds:
  - divisor == 0: DIV/DIVU return all ones; REM/REMU return rs1.
  - signed overflow (rs1 == -2^(XLEN-1), rs2 == -1, DIV/REM): DIV returns rs1, REM returns 0.
- Latency:
  - Normal: resp_valid rises XLEN+1 cycles after the accept cycle.
  - Fast path: resp_valid rises 1 cycle after the accept cycle.
- DONE: resp_valid = 1; resp_data/rd/tag held stable until resp_valid && resp_ready, then go to IDLE. No new accept in the handshake cycle (req_ready is 0 in DONE).
- Flush in any non-IDLE state: next edge goes to IDLE, resp_valid = 0, result discarded. Flush in IDLE blocks acceptance that cycle.
- Flush and resp_ready asserted together in DONE: treated as a flush. Execute must not count the response as retired.
- resp_data/rd/tag hold their last value outside DONE; only resp_valid qualifies them.
- x0 destination is not special-cased; execute masks the write.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- When defined:
  - Multiply with either operand 0 takes the fast path, result 0.
  - Unsigned-magnitude |rs1| < |rs2| divide takes the fast path: quotient 0, remainder rs1.
  - Both complete in 1 cycle.
- When undefined: these cases take the full XLEN-cycle path with identical results.

Test Plan:
- XLEN=32, MUL 7 × -3 → resp_data 0xFFFFFFEB after exactly 33 cycles; resp_tag/resp_rd echo inputs.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULH same operands → 0x00000000; MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV -7 / 2 → 0xFFFFFFFD; REM -7 / 2 → 0xFFFFFFFF; DIVU 100 / 0 → 0xFFFFFFFF in 1 cycle; DIV 0x80000000 / -1 → 0x80000000, REM → 0.
- Hold resp_ready = 0 for 5 cycles in DONE → resp_valid and resp_data stable, req_ready 0; release → IDLE next cycle, req_ready 1.
- Flush at BUSY cycle 10 → no resp_valid ever; new DIVU 9/3 accepted the cycle after and returns 3.
- rst low during MUL cycle 5 → all outputs 0 next edge; with MULDIV_EARLY_OUT_EN, DIVU 3/9 → quotient 0 in 1 cycle, REMU 3/9 → 3.
